// File: rtl/sample_stream_src_pkg.sv
// Shared types and sizing helpers for the sample stream source.
// Contents: default sample width, replay state encoding, and the
// count/pointer width helper used for port and register sizing.
package sample_stream_pkg;

    localparam int unsigned DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Width needed to hold 0..depth inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_stream_src_if.sv
// Sample stream bus from the source to the running-max consumer.
// Signals: out_valid (sample present this cycle), out_data (sample value,
// holds when out_valid is low). master = producer, slave = consumer.
interface sample_stream_src_if #(
    parameter int unsigned DATA_W = 4
);
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    modport master (output out_valid, output out_data);
    modport slave  (input  out_valid, input  out_data);
endinterface

// File: rtl/sample_buf.sv
// Sample storage: DEPTH x DATA_W register array, one synchronous write
// port and one combinational read port. Storage has no reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module sample_buf #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sample_stream_src.sv
// Programmable sample stream source: buffers up to DEPTH samples while
// idle, then replays them on the stream interface with a programmable
// number of idle cycles between samples, followed by a one-cycle done.
// Ports: clk, reset (sync, active low); wr_en/wr_data/clr/start/gap
// control (honoured only when idle); full/count/busy/done status;
// strm (master) carries out_valid/out_data.
// Optional: SAMPLE_STREAM_SRC_EXP_MAX_EN adds exp_largest, the running
// max of the streamed samples, cleared on reset and on each accepted start.
module sample_stream_src
    import sample_stream_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned GAP_W  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [DATA_W-1:0]         wr_data,
    input  logic                      clr,
    input  logic                      start,
    input  logic [GAP_W-1:0]          gap,
    output logic                      full,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      busy,
    output logic                      done,
`ifdef SAMPLE_STREAM_SRC_EXP_MAX_EN
    output logic [DATA_W-1:0]         exp_largest,
`endif
    sample_stream_src_if.master       strm
);

    localparam int unsigned CW = cnt_w(DEPTH);
    localparam int unsigned PW = $clog2(DEPTH);

    state_t            state;
    logic [PW-1:0]     rd_ptr;
    logic [GAP_W-1:0]  gap_q;
    logic [GAP_W-1:0]  gap_cnt;
    logic [DATA_W-1:0] rd_data;

    logic start_acc_c;
    logic buf_we_c;
    logic last_c;

    // Idle-side command decode: clr > start > wr_en.
    assign start_acc_c = (state == IDLE) && !clr && start && (count != '0);
    assign buf_we_c    = (state == IDLE) && !clr && !start_acc_c && wr_en && !full;
    assign last_c      = (CW'(rd_ptr) == (count - CW'(1)));

    // count doubles as the write pointer.
    sample_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we_c),
        .waddr (count[PW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    // Replay FSM with registered outputs; outputs lag the state by one edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            rd_ptr        <= '0;
            gap_q         <= '0;
            gap_cnt       <= '0;
            full          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            strm.out_valid <= 1'b0;
            strm.out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    strm.out_valid <= 1'b0;
                    done           <= 1'b0;
                    if (clr) begin
                        count <= '0;
                        full  <= 1'b0;
                    end else if (start_acc_c) begin
                        gap_q  <= gap;
                        rd_ptr <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else if (buf_we_c) begin
                        count <= count + CW'(1);
                        full  <= (count == CW'(DEPTH - 1));
                    end
                end
                RUN: begin
                    strm.out_valid <= 1'b1;
                    strm.out_data  <= rd_data;
                    if (last_c) begin
                        state <= DONE;
                    end else if (gap_q != '0) begin
                        gap_cnt <= gap_q;
                        state   <= GAP;
                    end else begin
                        rd_ptr <= rd_ptr + PW'(1);
                    end
                end
                GAP: begin
                    strm.out_valid <= 1'b0;
                    if (gap_cnt == GAP_W'(1)) begin
                        rd_ptr <= rd_ptr + PW'(1);
                        state  <= RUN;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                DONE: begin
                    strm.out_valid <= 1'b0;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SAMPLE_STREAM_SRC_EXP_MAX_EN
    // Running max of emitted samples, one cycle behind out_data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exp_largest <= '0;
        end else if (start_acc_c) begin
            exp_largest <= '0;
        end else if (strm.out_valid && (strm.out_data > exp_largest)) begin
            exp_largest <= strm.out_data;
        end
    end
`endif

endmodule

// File: tb/tb_sample_stream_src.sv
// Scoreboard bench for sample_stream_src: stimulus pushes expected
// stream events (sample or done, with the cycle they must appear in);
// a negedge monitor pops and compares whenever out_valid or done is seen.
module tb_sample_stream_src;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned GAP_W  = 3;

    typedef struct {
        bit           is_done;
        logic [3:0]   data;
        int           cyc;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              clr = 1'b0;
    logic              start = 1'b0;
    logic [GAP_W-1:0]  gap = '0;
    logic              full;
    logic [3:0]        count;
    logic              busy;
    logic              done;
`ifdef SAMPLE_STREAM_SRC_EXP_MAX_EN
    logic [DATA_W-1:0] exp_largest;
`endif

    sample_stream_src_if #(.DATA_W(DATA_W)) strm ();

    sample_stream_src #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .GAP_W  (GAP_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .clr         (clr),
        .start       (start),
        .gap         (gap),
        .full        (full),
        .count       (count),
        .busy        (busy),
        .done        (done),
`ifdef SAMPLE_STREAM_SRC_EXP_MAX_EN
        .exp_largest (exp_largest),
`endif
        .strm        (strm.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rst_edge = 1'b1;
    ev_t q[$];
    logic [3:0] pat[$];
    logic [3:0] last_exp = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_edge <= !reset;
    end

    // Monitor: compare every presented event against the scoreboard.
    always @(negedge clk) begin
        ev_t e;
        if (rst_edge) begin
            last_exp = '0;
        end else if (strm.out_valid || done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d valid=%0b done=%0b data=%0d required=no_event",
                         cyc, strm.out_valid, done, strm.out_data);
            end else begin
                e = q.pop_front();
                if ((done !== e.is_done) || (strm.out_valid !== !e.is_done) ||
                    (e.cyc != cyc) || (!e.is_done && strm.out_data !== e.data)) begin
                    errors++;
                    $display("FAIL stream_event actual: cyc=%0d valid=%0b done=%0b data=%0d required: cyc=%0d done=%0b data=%0d",
                             cyc, strm.out_valid, done, strm.out_data, e.cyc, e.is_done, e.data);
                end
                if (!e.is_done) last_exp = e.data;
            end
        end else begin
            checks++;
            if (strm.out_data !== last_exp) begin
                errors++;
                $display("FAIL data_hold cyc=%0d actual=%0d required=%0d", cyc, strm.out_data, last_exp);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic write_sample(input logic [3:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Pulse start with gap g over the samples in pat; if abort, expect only
    // the first two samples and no done. Returns at the negedge after the
    // start edge k (cyc == k).
    task automatic start_run(input int g, input bit abort);
        int k;
        int n;
        ev_t e;
        n     = pat.size();
        k     = cyc + 1;
        start = 1'b1;
        gap   = GAP_W'(g);
        for (int i = 0; i < n; i++) begin
            if (!abort || i < 2) begin
                e.is_done = 1'b0;
                e.data    = pat[i];
                e.cyc     = k + 1 + i * (g + 1);
                q.push_back(e);
            end
        end
        if (!abort) begin
            e.is_done = 1'b1;
            e.data    = '0;
            e.cyc     = k + 1 + (n - 1) * (g + 1) + 1;
            q.push_back(e);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            tick();
            t++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
            q.delete();
        end
        tick();
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_full", int'(full), 0);

        // Reset held 4 cycles in the middle of writing.
        write_sample(4'd1);
        write_sample(4'd2);
        chk("pre_reset_count", int'(count), 2);
        wr_en   = 1'b1;
        wr_data = 4'd3;
        reset   = 1'b0;
        repeat (4) tick();
        wr_en = 1'b0;
        reset = 1'b1;
        tick();
        chk("midwr_reset_count", int'(count), 0);
        chk("midwr_reset_valid", int'(strm.out_valid), 0);
        chk("midwr_reset_done", int'(done), 0);
        chk("midwr_reset_busy", int'(busy), 0);
        chk("midwr_reset_full", int'(full), 0);

        // Back-to-back replay with gap 0.
        write_sample(4'd5);
        write_sample(4'd4);
        write_sample(4'd6);
        chk("count_after_3", int'(count), 3);
        pat = '{4'd5, 4'd4, 4'd6};
        start_run(0, 1'b0);
        chk("busy_in_run", int'(busy), 1);
        wait_drain();
        chk("busy_after_done", int'(busy), 0);
        chk("count_retained", int'(count), 3);

        // Same buffer, gap 2; commands and gap changes during the run are ignored.
        start_run(2, 1'b0);
        gap     = '0;
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 4'd15;
        clr     = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        clr   = 1'b0;
        wait_drain();
        chk("count_after_ignored_cmds", int'(count), 3);

        // Fill past DEPTH, check saturation, replay to confirm contents.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_count", int'(count), 0);
        for (int i = 1; i <= 9; i++) begin
            write_sample(4'(i));
            if (i == 7) chk("full_at_7", int'(full), 0);
            if (i == 8) chk("full_at_8", int'(full), 1);
        end
        chk("count_sat", int'(count), 8);
        chk("full_sat", int'(full), 1);
        pat = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        start_run(1, 1'b0);
        wait_drain();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_count_full", int'(count), 0);
        chk("clr_full", int'(full), 0);

        // Start with an empty buffer is ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_start_busy", int'(busy), 0);
        repeat (3) tick();
        chk("empty_start_done", int'(done), 0);

        // Reset during the second sample aborts the replay.
        write_sample(4'd5);
        write_sample(4'd4);
        write_sample(4'd6);
        pat = '{4'd5, 4'd4, 4'd6};
        start_run(0, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_valid", int'(strm.out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        repeat (4) tick();
        chk("abort_count", int'(count), 0);
        chk("abort_queue", q.size(), 0);

`ifdef SAMPLE_STREAM_SRC_EXP_MAX_EN
        // Running max tracks the stream one cycle late; cleared on start.
        write_sample(4'd3);
        write_sample(4'd7);
        write_sample(4'd2);
        pat = '{4'd3, 4'd7, 4'd2};
        start_run(0, 1'b0);
        chk("exp_at_start", int'(exp_largest), 0);
        tick();
        tick();
        chk("exp_1", int'(exp_largest), 3);
        tick();
        chk("exp_2", int'(exp_largest), 7);
        tick();
        chk("exp_3", int'(exp_largest), 7);
        wait_drain();
        chk("exp_hold", int'(exp_largest), 7);
        start_run(0, 1'b0);
        chk("exp_cleared", int'(exp_largest), 0);
        wait_drain();
`endif

        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
